// File: rtl/alu_pkg.sv
`default_nettype none
//==============================================================================
// Module   : alu_pkg
// Brief    : Shared opcode constants, flag bit positions and FSM state encoding
//            for the operand-fetch ALU.
// Revision : 1.0 - initial release
//==============================================================================
package alu_pkg;

    localparam int c_op_w   = 4;
    localparam int c_flag_w = 4;

    // Opcode map; 10..15 are reserved and report err
    localparam logic [c_op_w-1:0] c_op_add = 4'd0;
    localparam logic [c_op_w-1:0] c_op_sub = 4'd1;
    localparam logic [c_op_w-1:0] c_op_and = 4'd2;
    localparam logic [c_op_w-1:0] c_op_or  = 4'd3;
    localparam logic [c_op_w-1:0] c_op_xor = 4'd4;
    localparam logic [c_op_w-1:0] c_op_nor = 4'd5;
    localparam logic [c_op_w-1:0] c_op_slt = 4'd6;
    localparam logic [c_op_w-1:0] c_op_sll = 4'd7;
    localparam logic [c_op_w-1:0] c_op_srl = 4'd8;
    localparam logic [c_op_w-1:0] c_op_sra = 4'd9;

    // Bit positions inside flags = {err, overflow, carry, zero}
    localparam int c_flag_zero  = 0;
    localparam int c_flag_carry = 1;
    localparam int c_flag_ovf   = 2;
    localparam int c_flag_err   = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // True for every opcode that has a defined operation
    function automatic logic op_is_valid(input logic [c_op_w-1:0] op);
        return (op <= c_op_sra);
    endfunction

endpackage
`default_nettype wire

// File: rtl/operand_fetch_alu_if.sv
`default_nettype none
//==============================================================================
// Module   : operand_fetch_alu_if
// Brief    : Command, operand-ROM and result bundle of the operand-fetch ALU.
//            slave = the ALU block, master = the command/ROM/consumer side.
// Revision : 1.0 - initial release
//==============================================================================
interface operand_fetch_alu_if
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);

    logic                  cmdValid;
    logic                  cmdReady;
    logic [c_op_w-1:0]     cmdOp;
    logic [ADDR_W-1:0]     cmdAddrA;
    logic [ADDR_W-1:0]     cmdAddrB;
    logic [ADDR_W-1:0]     addressA;
    logic [ADDR_W-1:0]     addressB;
    logic [DATA_W-1:0]     dataA;
    logic [DATA_W-1:0]     dataB;
    logic                  resValid;
    logic                  resReady;
    logic [DATA_W-1:0]     result;
    logic [c_flag_w-1:0]   flags;

    modport slave (
        input  cmdValid, cmdOp, cmdAddrA, cmdAddrB, dataA, dataB, resReady,
        output cmdReady, addressA, addressB, resValid, result, flags
    );

    modport master (
        output cmdValid, cmdOp, cmdAddrA, cmdAddrB, dataA, dataB, resReady,
        input  cmdReady, addressA, addressB, resValid, result, flags
    );

endinterface
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
//==============================================================================
// Module   : alu_core
// Brief    : Purely combinational ALU: opA/opB/op -> result and
//            {err, overflow, carry, zero} flags.
// Revision : 1.0 - initial release
//==============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   opA,
    input  logic [DATA_W-1:0]   opB,
    input  logic [c_op_w-1:0]   op,
    output logic [DATA_W-1:0]   result,
    output logic [c_flag_w-1:0] flags
);

    // One extra bit on the adders exposes the carry-out
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic [4:0]        w_shamt;
    logic              w_lt;
    logic              w_carry;
    logic              w_ovf;
    logic              w_err;
    logic              w_valid;

    assign w_sum   = {1'b0, opA} + {1'b0, opB};
    // Subtraction as A + ~B + 1 so carry = 1 means no borrow
    assign w_diff  = {1'b0, opA} + {1'b0, ~opB} + {{DATA_W{1'b0}}, 1'b1};
    assign w_shamt = opB[4:0];
    assign w_lt    = ($signed(opA) < $signed(opB));
    assign w_valid = op_is_valid(op);

    // Operation select plus carry/overflow/err generation
    always_comb begin
        result  = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_err   = 1'b0;
        case (op)
            c_op_add: begin
                result  = w_sum[DATA_W-1:0];
                w_carry = w_sum[DATA_W];
                w_ovf   = (opA[DATA_W-1] == opB[DATA_W-1]) &&
                          (w_sum[DATA_W-1] != opA[DATA_W-1]);
            end
            c_op_sub: begin
                result  = w_diff[DATA_W-1:0];
                w_carry = w_diff[DATA_W];
                w_ovf   = (opA[DATA_W-1] != opB[DATA_W-1]) &&
                          (w_diff[DATA_W-1] != opA[DATA_W-1]);
            end
            c_op_and: result = opA & opB;
            c_op_or:  result = opA | opB;
            c_op_xor: result = opA ^ opB;
            c_op_nor: result = ~(opA | opB);
            c_op_slt: result = {{(DATA_W-1){1'b0}}, w_lt};
            c_op_sll: result = opA << w_shamt;
            c_op_srl: result = opA >> w_shamt;
            c_op_sra: result = DATA_W'($signed(opA) >>> w_shamt);
            default:  w_err  = 1'b1;
        endcase
    end

    // Pack flags; zero is only meaningful for defined opcodes
    always_comb begin
        flags               = '0;
        flags[c_flag_zero]  = w_valid && (result == '0);
        flags[c_flag_carry] = w_carry;
        flags[c_flag_ovf]   = w_ovf;
        flags[c_flag_err]   = w_err;
    end

endmodule
`default_nettype wire

// File: rtl/operand_fetch_alu.sv
`default_nettype none
//==============================================================================
// Module   : operand_fetch_alu
// Brief    : Accepts a command, reads two operands from an external dual-port
//            ROM, executes one ALU operation and holds the result until the
//            consumer takes it. One command in flight, no queuing.
// Revision : 1.0 - initial release
//==============================================================================
module operand_fetch_alu
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    operand_fetch_alu_if.slave bus
);

    state_t                r_state;
    state_t                w_next_state;
    logic [c_op_w-1:0]     r_op;
    logic [ADDR_W-1:0]     r_addr_a;
    logic [ADDR_W-1:0]     r_addr_b;
    logic [DATA_W-1:0]     r_op_a;
    logic [DATA_W-1:0]     r_op_b;
    logic [DATA_W-1:0]     r_result;
    logic [c_flag_w-1:0]   r_flags;
    logic [DATA_W-1:0]     w_alu_result;
    logic [c_flag_w-1:0]   w_alu_flags;
    logic                  w_cmd_ready;
    logic                  w_res_valid;
    logic                  w_accept;

    assign w_accept = w_cmd_ready && bus.cmdValid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs; cmdReady is held low while in reset
    always_comb begin
        w_next_state = r_state;
        w_cmd_ready  = 1'b0;
        w_res_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cmd_ready = rst_n;
                if (rst_n && bus.cmdValid) begin
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_DONE;
            S_DONE: begin
                w_res_valid = 1'b1;
                if (bus.resReady) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Command capture: opcode and ROM addresses change only on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_addr_a <= '0;
            r_addr_b <= '0;
        end else if (w_accept) begin
            r_op     <= bus.cmdOp;
            r_addr_a <= bus.cmdAddrA;
            r_addr_b <= bus.cmdAddrB;
        end
    end

    // Operand capture from the ROM during FETCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a <= '0;
            r_op_b <= '0;
        end else if (r_state == S_FETCH) begin
            r_op_a <= bus.dataA;
            r_op_b <= bus.dataB;
        end
    end

    // Result/flags register loaded in EXEC and held through DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_flags  <= '0;
        end else if (r_state == S_EXEC) begin
            r_result <= w_alu_result;
            r_flags  <= w_alu_flags;
        end
    end

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu_core (
        .opA    (r_op_a),
        .opB    (r_op_b),
        .op     (r_op),
        .result (w_alu_result),
        .flags  (w_alu_flags)
    );

    assign bus.cmdReady = w_cmd_ready;
    assign bus.resValid = w_res_valid;
    assign bus.addressA = r_addr_a;
    assign bus.addressB = r_addr_b;
    assign bus.result   = r_result;
    assign bus.flags    = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch_alu.sv
`default_nettype none
//==============================================================================
// Module   : tb_operand_fetch_alu
// Brief    : Scoreboard bench for operand_fetch_alu with a behavioural ROM.
// Revision : 1.0 - initial release
//==============================================================================
module tb_operand_fetch_alu;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic [3:0]        flg;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] rom [16];
    exp_t              sb_q [$];
    int                total;
    int                bad;

    operand_fetch_alu_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    operand_fetch_alu #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.dataA = rom[bus.addressA];
    assign bus.dataB = rom[bus.addressB];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per result handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.resValid && bus.resReady) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got %h expected none", bus.result);
                end else begin
                    e = sb_q.pop_front();
                    chk("result", bus.result, e.res);
                    chk("flags", {28'd0, bus.flags}, {28'd0, e.flg});
                end
            end
        end
    end

    // Offer a command; optionally record its expected response
    task automatic drive_cmd(input logic [3:0] op, input logic [3:0] a,
                             input logic [3:0] b, input logic [DATA_W-1:0] res,
                             input logic [3:0] flg, input bit push);
        exp_t e;
        e.res = res;
        e.flg = flg;
        if (push) sb_q.push_back(e);
        bus.cmdOp    = op;
        bus.cmdAddrA = a;
        bus.cmdAddrB = b;
        bus.cmdValid = 1'b1;
    endtask

    // Wait for acceptance; returns #1 after the accepting edge
    task automatic wait_accept(output int edges);
        logic ok;
        edges = 0;
        ok    = 1'b0;
        while (!ok && edges < 50) begin
            @(negedge clk);
            ok = bus.cmdReady && bus.cmdValid;
            @(posedge clk);
            #1;
            edges++;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no accept expected accept");
        end
        bus.cmdValid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || !bus.cmdReady) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got pending=%0d expected 0", sb_q.size());
        end
    endtask

    task automatic run(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [DATA_W-1:0] res, input logic [3:0] flg);
        int e;
        drive_cmd(op, a, b, res, flg, 1'b1);
        wait_accept(e);
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        int cyc;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 16; i++) rom[i] = 32'h0;
        rom[0]  = 32'hFFFF_FFFF;
        rom[1]  = 32'h0000_0001;
        rom[2]  = 32'h0000_0005;
        rom[3]  = 32'h0000_0007;
        rom[4]  = 32'h7FFF_FFFF;
        rom[5]  = 32'h8000_0000;
        rom[6]  = 32'h0F0F_00FF;
        rom[7]  = 32'h00FF_0FF0;
        rom[8]  = 32'h0000_0004;
        rom[15] = 32'h1234_5678;

        rst_n        = 1'b0;
        bus.cmdValid = 1'b0;
        bus.cmdOp    = 4'd0;
        bus.cmdAddrA = 4'd0;
        bus.cmdAddrB = 4'd0;
        bus.resReady = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmdReady_low", {31'd0, bus.cmdReady}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_cmdReady", {31'd0, bus.cmdReady}, 32'd1);
        chk("rst_resValid", {31'd0, bus.resValid}, 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_flags", {28'd0, bus.flags}, 32'd0);
        chk("rst_addressA", {28'd0, bus.addressA}, 32'd0);

        // ADD 5+7 with latency: the accepting edge is the first of three,
        // so resValid is seen after two further edges
        drive_cmd(4'd0, 4'd2, 4'd3, 32'd12, 4'b0000, 1'b1);
        wait_accept(edges);
        chk("addressA_loaded", {28'd0, bus.addressA}, 32'd2);
        chk("addressB_loaded", {28'd0, bus.addressB}, 32'd3);
        cyc = 0;
        while (!bus.resValid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency_edges", cyc, 32'd2);
        wait_drain();

        // Carry / borrow / overflow / compare / error / shifts / logic
        run(4'd0, 4'd0, 4'd1, 32'h0000_0000, 4'b0011);
        run(4'd1, 4'd1, 4'd0, 32'h0000_0002, 4'b0000);
        run(4'd0, 4'd4, 4'd1, 32'h8000_0000, 4'b0100);
        run(4'd6, 4'd5, 4'd1, 32'h0000_0001, 4'b0000);
        run(4'd12, 4'd2, 4'd3, 32'h0000_0000, 4'b1000);
        run(4'd9, 4'd5, 4'd8, 32'hF800_0000, 4'b0000);
        run(4'd2, 4'd6, 4'd7, 32'h000F_00F0, 4'b0000);
        run(4'd3, 4'd6, 4'd7, 32'h0FFF_0FFF, 4'b0000);
        run(4'd4, 4'd6, 4'd7, 32'h0FF0_0F0F, 4'b0000);
        run(4'd5, 4'd6, 4'd7, 32'hF000_F000, 4'b0000);
        run(4'd7, 4'd2, 4'd8, 32'h0000_0050, 4'b0000);
        run(4'd8, 4'd5, 4'd8, 32'h0800_0000, 4'b0000);
        run(4'd1, 4'd3, 4'd3, 32'h0000_0000, 4'b0011);
        run(4'd4, 4'd3, 4'd3, 32'h0000_0000, 4'b0001);
        run(4'd0, 4'd15, 4'd15, 32'h2468_ACF0, 4'b0000);

        // Backpressure in DONE with a competing command offered
        bus.resReady = 1'b0;
        drive_cmd(4'd0, 4'd2, 4'd3, 32'd12, 4'b0000, 1'b1);
        wait_accept(edges);
        cyc = 0;
        while (!bus.resValid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        drive_cmd(4'd1, 4'd3, 4'd2, 32'd2, 4'b0010, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("hold_result", bus.result, 32'd12);
            chk("hold_cmdReady", {31'd0, bus.cmdReady}, 32'd0);
            chk("hold_resValid", {31'd0, bus.resValid}, 32'd1);
        end
        chk("hold_addressA", {28'd0, bus.addressA}, 32'd2);
        bus.resReady = 1'b1;
        wait_accept(edges);
        chk("accept_after_handshake", edges, 32'd2);
        wait_drain();

        // Reset during EXEC aborts the command without a result
        drive_cmd(4'd0, 4'd2, 4'd3, 32'd12, 4'b0000, 1'b0);
        wait_accept(edges);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_resValid", {31'd0, bus.resValid}, 32'd0);
        chk("abort_result", bus.result, 32'd0);
        chk("abort_flags", {28'd0, bus.flags}, 32'd0);
        chk("abort_addressA", {28'd0, bus.addressA}, 32'd0);
        chk("abort_cmdReady", {31'd0, bus.cmdReady}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("abort_cmdReady_after", {31'd0, bus.cmdReady}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_result", {31'd0, bus.resValid}, 32'd0);
        run(4'd0, 4'd6, 4'd7, 32'h100E_10EF, 4'b0000);

        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/operand_fetch_alu.md
OPERAND_FETCH_ALU -- requirements
Module: operand_fetch_alu

Interface
REQ-001 Parameter: DATA_W, default 32, operand/result width.
REQ-002 Parameter: ADDR_W, default 4, operand memory address width (16 words).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cmdValid  input  1  command offered.
REQ-006 cmdReady  output  1  block accepts command this cycle.
REQ-007 cmdOp  input  4  operation code.
REQ-008 cmdAddrA / cmdAddrB  input  ADDR_W each  operand word addresses.
REQ-009 addressA / addressB  output  ADDR_W each  read addresses to the dual-port operand ROM, registered.
REQ-010 dataA / dataB  input  DATA_W each  combinational ROM read data for addressA/addressB.
REQ-011 resValid  output  1  result available.
REQ-012 resReady  input  1  consumer takes result.
REQ-013 result  output  DATA_W  ALU result.
REQ-014 flags  output  4  {err, overflow, carry, zero}.

Function
REQ-015 FSM states: IDLE, FETCH, EXEC, DONE; cmdReady = 1 only in IDLE.
REQ-016 IDLE: cmdValid & cmdReady -> latch cmdOp; load addressA/addressB from cmdAddrA/B; go to FETCH.
REQ-017 FETCH: capture dataA/dataB into opA/opB registers; go to EXEC.
REQ-018 EXEC: register result and flags from opA/opB/op; go to DONE.
REQ-019 DONE: resValid = 1; result/flags stable until resValid & resReady, then go to IDLE.
REQ-020 Latency: resValid rises on the 3rd rising edge after the accepting edge; minimum 4 cycles per command.
REQ-021 resReady asserted outside DONE is ignored; cmdValid outside IDLE is ignored, with no queuing.
REQ-022 addressA/addressB hold their last values outside IDLE-accept.
REQ-023 Ops: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT signed (result 1/0), 7 SLL, 8 SRL, 9 SRA; shift amount = opB[4:0].
REQ-024 Opcodes 10-15: result = 0, err = 1, other flags 0.
REQ-025 zero = (result == 0) for all valid ops.
REQ-026 carry: ADD = carry-out of bit DATA_W-1; SUB = carry-out of A + ~B + 1 (1 means no borrow); 0 for other ops.
REQ-027 overflow: two's-complement signed overflow for ADD/SUB; 0 otherwise.
REQ-028 Arithmetic is modulo 2^DATA_W; address values wrap naturally (15 valid, no bounds check).
REQ-029 cmdAddrA == cmdAddrB is legal; both operands read the same word.

Reset
REQ-030 rst_n low: state = IDLE; addressA/B, opA/opB, result, flags = 0; resValid = 0; cmdReady = 1 once rst_n is high.
REQ-031 Reset asserted in any state aborts the operation; no result is produced for the aborted command.

Structure
REQ-032 Shared package alu_pkg holds the opcode constants, the FSM state enum, and the flag bit positions.
REQ-033 Combinational sub-module alu_core (opA, opB, op -> result, flags) is instantiated once; the FSM and registers stay in operand_fetch_alu.

Verification
REQ-034 ROM[2]=5, ROM[3]=7; ADD A=2 B=3 -> result 12, flags 0000, resValid 3 edges after accept.
REQ-035 ROM[0]=0xFFFFFFFF, ROM[1]=1; ADD -> result 0, zero=1, carry=1, overflow=0; SUB(1 - 0xFFFFFFFF) -> result 2, carry=0.
REQ-036 ROM[4]=0x7FFFFFFF, ROM[1]=1; ADD -> 0x80000000, overflow=1; SLT(0x80000000 vs 1) -> 1.
REQ-037 Hold resReady=0 for 5 cycles in DONE while driving new cmdValid -> result stable, cmdReady=0, second command accepted only after the handshake.
REQ-038 Opcode 12 -> result 0, err=1; SRA ROM word 0x80000000 by 4 -> 0xF8000000.
REQ-039 Assert rst_n low during EXEC -> resValid stays 0, all outputs 0, next command completes normally.
